pump_batch_controller: RTL and testbench

- Preset-volume dispense controller. Generates the relay enable (`relay_manual`) and the volume-clear strobe (`vol_clr`, wired to the volume accumulator's `sw0`).
- Consumes that accumulator's `thetichdabom` output and stops the pump once the operator's preset volume has been dispensed.
- Enforces a tank-low interlock and a stall watchdog.
- Sits between the front-panel buttons / tank level sensor and the volume accumulator; runs on the system 1 MHz clock.

---
 rtl/pump_pkg.sv | 18 +
 rtl/pump_batch_controller_btn_debounce.sv | 48 ++++
 rtl/pump_batch_controller.sv | 118 +++++++++++
 tb/tb_pump_batch_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pump_pkg.sv
// Shared definitions for the preset-volume pump controller: state encodings,
// accumulator step size and default timing parameters.
`timescale 1ns/1ps
package pump_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_PUMP  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } pump_state_t;

    localparam int VOL_STEP            = 50;
    localparam int DEBOUNCE_CYCLES_DEF = 20000;
    localparam int STALL_CYCLES_DEF    = 4000000;

endpackage

// File: rtl/pump_batch_controller_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-sample debounce counter and
// a one-cycle pulse on the debounced rising edge.
`timescale 1ns/1ps
module btn_debounce
    import pump_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;

    // The counter only runs while the synchronized sample disagrees with the
    // accepted level; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_pulse <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_pulse <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/pump_batch_controller.sv
// Preset-volume dispense controller: drives the pump relay and accumulator
// clear, stops at the latched target, with tank-low interlock and stall watchdog.
`timescale 1ns/1ps
module pump_batch_controller
    import pump_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STALL_CYCLES    = STALL_CYCLES_DEF,
    parameter int VOL_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic [VOL_W-1:0] preset_vol,
    input  logic             tank_low,
    input  logic [VOL_W-1:0] thetichdabom,
    output logic             relay_manual,
    output logic             vol_clr,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [2:0]       state
);

    localparam int                STALL_W    = $clog2(STALL_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

    logic             w_start_p;
    logic             w_stop_p;
    logic             w_start_ok;
    pump_state_t      w_state_nxt;

    pump_state_t      r_state;
    logic [VOL_W-1:0] r_target;
    logic [VOL_W-1:0] r_vol_prev;
    logic [STALL_W-1:0] r_stall;
    logic             r_relay;
    logic             r_vol_clr;
    logic             r_busy;
    logic             r_done;
    logic             r_fault;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_start),
        .o_pulse (w_start_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_stop),
        .o_pulse (w_stop_p)
    );

    assign w_start_ok = w_start_p && (preset_vol != '0) && !tank_low;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_ARM;
            S_ARM:   w_state_nxt = S_PUMP;
            S_PUMP: begin
                if (tank_low)                        w_state_nxt = S_FAULT;
                else if (thetichdabom >= r_target)   w_state_nxt = S_DONE;
                else if (w_stop_p)                   w_state_nxt = S_IDLE;
                else if (r_stall == STALL_LAST)      w_state_nxt = S_FAULT;
            end
            S_DONE: begin
                if (w_stop_p)        w_state_nxt = S_IDLE;
                else if (w_start_ok) w_state_nxt = S_ARM;
            end
            S_FAULT: if (w_stop_p && !tank_low) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state register and stay glitch-free Moore outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_vol_prev <= '0;
            r_stall    <= '0;
            r_relay    <= 1'b0;
            r_vol_clr  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_relay    <= (w_state_nxt == S_PUMP);
            r_vol_clr  <= (w_state_nxt == S_ARM);
            r_busy     <= (w_state_nxt == S_ARM) || (w_state_nxt == S_PUMP);
            r_done     <= (w_state_nxt == S_DONE);
            r_fault    <= (w_state_nxt == S_FAULT);
            r_vol_prev <= thetichdabom;
            if (w_state_nxt == S_ARM) r_target <= preset_vol;
            // Stall run restarts on PUMP entry and on every volume movement.
            if ((r_state != S_PUMP) || (thetichdabom != r_vol_prev)) begin
                r_stall <= '0;
            end else if (r_stall != STALL_LAST) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign relay_manual = r_relay;
    assign vol_clr      = r_vol_clr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign fault        = r_fault;
    assign state        = r_state;

endmodule

// File: tb/tb_pump_batch_controller.sv
// Directed bench for pump_batch_controller with a behavioural volume
// accumulator (+50 every 10 relay-on cycles, cleared by vol_clr).
`timescale 1ns/1ps
module tb_pump_batch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_stop = 1'b0;
    logic [15:0] preset_vol = 16'd0;
    logic        tank_low = 1'b0;
    logic [15:0] acc = 16'd0;
    logic        relay_manual, vol_clr, busy, done, fault;
    logic [2:0]  state;

    logic [3:0]  tick = 4'd0;
    logic        freeze = 1'b0;
    int          relay_cnt = 0;
    int          arm_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    pump_batch_controller #(
        .DEBOUNCE_CYCLES (4),
        .STALL_CYCLES    (100),
        .VOL_W           (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_start    (btn_start),
        .btn_stop     (btn_stop),
        .preset_vol   (preset_vol),
        .tank_low     (tank_low),
        .thetichdabom (acc),
        .relay_manual (relay_manual),
        .vol_clr      (vol_clr),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Accumulator model; freeze holds it at 100 for the stall scenario.
    always @(posedge clk) begin
        if (vol_clr) begin
            acc  <= 16'd0;
            tick <= 4'd0;
        end else if (relay_manual && !(freeze && acc >= 16'd100)) begin
            if (tick == 4'd9) begin
                tick <= 4'd0;
                acc  <= acc + 16'd50;
            end else begin
                tick <= tick + 4'd1;
            end
        end
        if (relay_manual) relay_cnt <= relay_cnt + 1;
        if (vol_clr)      arm_cnt   <= arm_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press start from state pre_st: pulse after 6 edges, ARM visible at the
    // 7th negedge, PUMP at the 8th; start is released on return.
    task automatic start_batch(input string tag, input logic [15:0] p, input logic [2:0] pre_st);
        preset_vol = p;
        btn_start  = 1'b1;
        step(6);
        check({tag, "_pre"}, 32'(state), 32'(pre_st));
        step(1);
        check({tag, "_arm"}, 32'(state), 1);
        check({tag, "_clr"}, 32'(vol_clr), 1);
        check({tag, "_busy"}, 32'(busy), 1);
        step(1);
        check({tag, "_pump"}, 32'(state), 2);
        check({tag, "_relay"}, 32'(relay_manual), 1);
        check({tag, "_clr1"}, 32'(vol_clr), 0);
        btn_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step(1);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 1);
    endtask

    task automatic wait_vol(input string tag, input logic [15:0] v, input int budget);
        int n = 0;
        while (acc != v && n < budget) begin
            step(1);
            n++;
        end
        check({tag, "_vol_seen"}, 32'(acc), 32'(v));
    endtask

    initial begin
        int rc0;
        int a0;

        step(3);
        check("rst_state", 32'(state), 0);
        check("rst_relay", 32'(relay_manual), 0);
        check("rst_clr", 32'(vol_clr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fault", 32'(fault), 0);
        rst_n = 1'b1;
        step(2);

        // Normal batch: 300 reached on the 6th step, relay drops one cycle later.
        rc0 = relay_cnt;
        a0  = arm_cnt;
        start_batch("norm", 16'd300, 3'd0);
        wait_done("norm", 200);
        check("norm_relay_cycles", 32'(relay_cnt - rc0), 61);
        check("norm_relay_off", 32'(relay_manual), 0);
        check("norm_state", 32'(state), 3);
        step(20);
        check("norm_vol_hold", 32'(acc), 300);
        check("norm_one_arm", 32'(arm_cnt - a0), 1);

        // Overshoot: new batch from DONE, target 120 stops at 150.
        rc0 = relay_cnt;
        start_batch("ovs", 16'd120, 3'd3);
        wait_done("ovs", 200);
        check("ovs_vol", 32'(acc), 150);
        check("ovs_relay_cycles", 32'(relay_cnt - rc0), 31);
        step(10);

        // Manual stop at 200; preset change after latching must be ignored.
        start_batch("stop", 16'd1000, 3'd3);
        preset_vol = 16'd50;
        wait_vol("stop", 16'd200, 200);
        btn_stop = 1'b1;
        step(6);
        check("stop_still_pump", 32'(relay_manual), 1);
        step(1);
        check("stop_state", 32'(state), 0);
        check("stop_relay", 32'(relay_manual), 0);
        check("stop_done", 32'(done), 0);
        check("stop_fault", 32'(fault), 0);
        check("stop_vol", 32'(acc), 200);
        btn_stop = 1'b0;
        step(10);

        // Interlock: start ignored while tank is low.
        tank_low   = 1'b1;
        preset_vol = 16'd300;
        a0         = arm_cnt;
        btn_start  = 1'b1;
        step(12);
        check("ilk_idle", 32'(state), 0);
        check("ilk_no_arm", 32'(arm_cnt - a0), 0);
        btn_start = 1'b0;
        step(10);
        tank_low = 1'b0;
        start_batch("ilk", 16'd300, 3'd0);
        step(8);
        tank_low = 1'b1;
        step(1);
        check("ilk_fault_state", 32'(state), 4);
        check("ilk_fault", 32'(fault), 1);
        check("ilk_relay", 32'(relay_manual), 0);
        check("ilk_busy", 32'(busy), 0);
        btn_stop = 1'b1;
        step(12);
        check("ilk_stop_low", 32'(state), 4);
        btn_stop = 1'b0;
        step(10);
        tank_low = 1'b0;
        btn_stop = 1'b1;
        step(6);
        check("ilk_pre_clear", 32'(state), 4);
        step(1);
        check("ilk_cleared", 32'(state), 0);
        check("ilk_fault_off", 32'(fault), 0);
        btn_stop = 1'b0;
        step(10);

        // Stall: the controller sees the last change (50->100) one edge after
        // the accumulator moves; 100 cycles later the watchdog trips.
        freeze = 1'b1;
        start_batch("stall", 16'd1000, 3'd0);
        wait_vol("stall", 16'd100, 100);
        step(100);
        check("stall_not_yet", 32'(fault), 0);
        check("stall_pump", 32'(state), 2);
        step(1);
        check("stall_fault", 32'(fault), 1);
        check("stall_state", 32'(state), 4);
        check("stall_relay", 32'(relay_manual), 0);
        freeze   = 1'b0;
        btn_stop = 1'b1;
        step(7);
        check("stall_cleared", 32'(state), 0);
        btn_stop = 1'b0;
        step(10);

        // 3-cycle start glitch is rejected.
        preset_vol = 16'd300;
        a0         = arm_cnt;
        btn_start  = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(15);
        check("glitch_idle", 32'(state), 0);
        check("glitch_no_arm", 32'(arm_cnt - a0), 0);

        // Start held 500 cycles: one batch, then DONE holds.
        a0        = arm_cnt;
        btn_start = 1'b1;
        step(500);
        check("hold_one_arm", 32'(arm_cnt - a0), 1);
        check("hold_done", 32'(state), 3);
        btn_start = 1'b0;
        step(10);
        btn_stop = 1'b1;
        step(7);
        check("hold_to_idle", 32'(state), 0);
        btn_stop = 1'b0;
        step(10);

        // Zero preset: start ignored.
        preset_vol = 16'd0;
        a0         = arm_cnt;
        btn_start  = 1'b1;
        step(12);
        check("zero_idle", 32'(state), 0);
        check("zero_no_arm", 32'(arm_cnt - a0), 0);
        btn_start = 1'b0;
        step(10);

        // Simultaneous start+stop in IDLE: start wins; then reset mid-PUMP.
        preset_vol = 16'd300;
        btn_start  = 1'b1;
        btn_stop   = 1'b1;
        step(6);
        check("both_pre", 32'(state), 0);
        step(1);
        check("both_arm", 32'(state), 1);
        step(1);
        check("both_pump", 32'(state), 2);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        step(5);
        a0    = arm_cnt;
        rst_n = 1'b0;
        step(1);
        check("rstp_relay", 32'(relay_manual), 0);
        check("rstp_busy", 32'(busy), 0);
        check("rstp_state", 32'(state), 0);
        check("rstp_clr", 32'(vol_clr), 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("rstp_no_clr", 32'(arm_cnt - a0), 0);
        check("rstp_idle", 32'(state), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
